arg_max_driver: RTL

- Stream source and result sink for the arg_max block.
- Holds one frame of signed I/Q samples in an internal buffer that a host loads through a simple write port.
- On a start pulse, streams the frame into arg_max using the valid/ready handshake, then accepts the single (out_max, index) result and holds it for the host.
- Port names on the arg_max side equal the arg_max port names, so the two blocks connect by name.

---
 rtl/caf_pkg.sv | 17 +
 rtl/iq_sample_ram.sv | 25 ++
 rtl/arg_max_driver.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/caf_pkg.sv
// Shared types and default widths for the arg_max driver slice.
package caf_pkg;

  localparam int I_BITS       = 12;
  localparam int Q_BITS       = 12;
  localparam int OUT_MAX_BITS = 25;
  localparam int INDEX_BITS   = 8;

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    STREAM,
    WAIT_RESULT,
    DONE
  } state_t;

endpackage

// File: rtl/iq_sample_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port, 1-cycle read latency.
module iq_sample_ram #(
  parameter int DATA_BITS = 24,
  parameter int ADDR_BITS = 8,
  parameter int DEPTH     = 256
) (
  input  logic                 clk,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_addr,
  input  logic [DATA_BITS-1:0] i_wr_data,
  input  logic                 i_rd_en,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [DATA_BITS-1:0] o_rd_data
);

  logic [DATA_BITS-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en && (int'(i_wr_addr) < DEPTH))
      r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en && (int'(i_rd_addr) < DEPTH))
      o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/arg_max_driver.sv
// Frame buffer and stream driver for arg_max: streams a loaded I/Q frame on start
// and captures the single (out_max, index) result for the host.
module arg_max_driver import caf_pkg::*; #(
  parameter int I_BITS       = caf_pkg::I_BITS,
  parameter int Q_BITS       = caf_pkg::Q_BITS,
  parameter int OUT_MAX_BITS = caf_pkg::OUT_MAX_BITS,
  parameter int INDEX_BITS   = caf_pkg::INDEX_BITS,
  parameter int LENGTH       = 256
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    wr_en,
  input  logic [INDEX_BITS-1:0]   wr_addr,
  input  logic [I_BITS-1:0]       wr_i,
  input  logic [Q_BITS-1:0]       wr_q,
  input  logic [INDEX_BITS:0]     frame_len,
  input  logic                    start,
  output logic                    busy,
  output logic [I_BITS-1:0]       xi,
  output logic [Q_BITS-1:0]       xq,
  output logic                    m_axis_tvalid,
  input  logic                    s_axis_tready,
  input  logic                    s_axis_tvalid,
  input  logic [OUT_MAX_BITS-1:0] out_max,
  input  logic [INDEX_BITS-1:0]   index,
  output logic                    m_axis_tready,
  output logic                    result_valid,
  output logic [OUT_MAX_BITS-1:0] result_max,
  output logic [INDEX_BITS-1:0]   result_index
);

  localparam int W = I_BITS + Q_BITS;
  localparam logic [INDEX_BITS:0] LEN_MAX = (INDEX_BITS+1)'(LENGTH);
  localparam logic [INDEX_BITS:0] ONE     = (INDEX_BITS+1)'(1);

  state_t                  r_state;
  logic [INDEX_BITS:0]     r_len;
  logic [INDEX_BITS:0]     r_rd_addr;
  logic [INDEX_BITS:0]     r_sent;
  logic                    r_rd_pend;
  logic [W-1:0]            r_out;
  logic                    r_out_vld;
  logic [W-1:0]            r_skid;
  logic                    r_skid_vld;
  logic                    r_busy;
  logic                    r_tready;
  logic                    r_res_vld;
  logic [OUT_MAX_BITS-1:0] r_res_max;
  logic [INDEX_BITS-1:0]   r_res_idx;

  logic [W-1:0] w_rd_data;
  logic         w_start_ok;
  logic         w_pop;
  logic [1:0]   w_occ;
  logic         w_rd_en;
  logic         w_wr_en;

  assign w_start_ok = start && (frame_len != '0) && (frame_len <= LEN_MAX);
  assign w_pop      = r_out_vld && s_axis_tready;
  assign w_wr_en    = wr_en && !r_busy;

  // Output register + skid + in-flight read never exceed two entries, so a read
  // is issued only when its data is guaranteed a slot on arrival.
  always_comb begin
    w_occ   = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_rd_pend};
    w_rd_en = ((r_state == PREFETCH) || (r_state == STREAM)) &&
              (r_rd_addr < r_len) &&
              ((w_occ - {1'b0, w_pop}) <= 2'd1);
  end

  iq_sample_ram #(
    .DATA_BITS (W),
    .ADDR_BITS (INDEX_BITS),
    .DEPTH     (LENGTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data ({wr_i, wr_q}),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_addr[INDEX_BITS-1:0]),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_rd_addr  <= '0;
      r_sent     <= '0;
      r_rd_pend  <= 1'b0;
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_skid     <= '0;
      r_skid_vld <= 1'b0;
      r_busy     <= 1'b0;
      r_tready   <= 1'b0;
      r_res_vld  <= 1'b0;
      r_res_max  <= '0;
      r_res_idx  <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_ok) begin
            r_len      <= frame_len;
            r_busy     <= 1'b1;
            r_res_vld  <= 1'b0;
            r_rd_addr  <= '0;
            r_sent     <= '0;
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_state    <= PREFETCH;
          end
        end
        PREFETCH: r_state <= STREAM;
        STREAM: begin
          if (!r_out_vld || w_pop) begin
            if (r_skid_vld) begin
              r_out      <= r_skid;
              r_out_vld  <= 1'b1;
              r_skid_vld <= r_rd_pend;
              if (r_rd_pend) r_skid <= w_rd_data;
            end else if (r_rd_pend) begin
              r_out     <= w_rd_data;
              r_out_vld <= 1'b1;
            end else begin
              r_out_vld <= 1'b0;
            end
          end else if (r_rd_pend) begin
            r_skid     <= w_rd_data;
            r_skid_vld <= 1'b1;
          end
          if (w_pop) begin
            r_sent <= r_sent + ONE;
            if (r_sent == (r_len - ONE)) begin
              r_out_vld <= 1'b0;
              r_tready  <= 1'b1;
              r_state   <= WAIT_RESULT;
            end
          end
        end
        WAIT_RESULT: begin
          if (s_axis_tvalid) begin
            r_res_max <= out_max;
            r_res_idx <= index;
            r_res_vld <= 1'b1;
            r_tready  <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_rd_en) r_rd_addr <= r_rd_addr + ONE;
      r_rd_pend <= w_rd_en;
    end
  end

  assign busy          = r_busy;
  assign xi            = r_out[W-1 -: I_BITS];
  assign xq            = r_out[Q_BITS-1:0];
  assign m_axis_tvalid = r_out_vld;
  assign m_axis_tready = r_tready;
  assign result_valid  = r_res_vld;
  assign result_max    = r_res_max;
  assign result_index  = r_res_idx;

endmodule
